gate_dispatcher: RTL and testbench
==================================

// Module: gate_dispatcher
// PURPOSE
// Schedules garbled-AND gate jobs onto NUM_LANES evaluator_and lanes (each lane = 4 SHA-1 garbled cores).
// Accepts jobs over a valid/ready stream and dispatches them round-robin, one per free lane.
// Holds each lane's operands stable until that lane's result is captured.
// Retires Gc/toSend tables in strict dispatch order on a valid/ready result stream.
// Sits between the gate-list sequencer and the evaluator_and array.
// PARAMETERS
// NUM_LANES  4     number of evaluator_and lanes; power of 2, >=2
// KW         80    wire-label / R width
// GW         64    gate-id width
// TIMEOUT    4095  max cycles a lane may stay in ISSUE+BUSY before timeout_err; 0 disables
// PORTS
// clk                in   1            clock
// reset_n            in   1            async active-low reset
// job_valid/job_ready in/out 1         job handshake
// job_ga, job_gb, job_r in KW          input labels Ga, Gb and global offset R
// job_gid            in   GW           gate id
// lane_input_valid   out  NUM_LANES    one-cycle issue pulse per lane
// lane_ga/gb/r       out  NUM_LANES*KW held operands; lane i in bits [i*KW +: KW]
// lane_gid           out  NUM_LANES*GW held gate id per lane
// lane_ready         in   NUM_LANES    lane ready to accept an issue
// lane_output_valid  in   NUM_LANES    lane digests valid (level)
// lane_gc/ts01/ts10/ts11 in NUM_LANES*KW lane Gc and toSend01/10/11
// res_valid/res_ready out/in 1         result handshake
// res_gid            out  GW           gate id of the result
// res_gc/ts01/ts10/ts11 out KW         captured Gc and garbled table rows
// inflight           out  clog2(N)+1   lanes not IDLE
// timeout_err        out  1            sticky; set on any lane timeout
// BEHAVIOUR
// - Reset (async): all lanes IDLE; disp_ptr=ret_ptr=0; every output, operand, captured-result reg and counter is 0.
// - Per-lane FSM: IDLE -> ISSUE -> BUSY -> DONE -> IDLE.
// - job_ready = (lane[disp_ptr]==IDLE); registered state only, no combinational path from res_ready.
// - On job_valid&&job_ready at cycle T: load job_* into lane[disp_ptr] operand regs; lane -> ISSUE; disp_ptr+1 (mod N, wraps).
// - ISSUE: lane_input_valid[i] = lane_ready[i]; exactly one cycle with both high. Earliest issue is T+1.
//   After that cycle: -> BUSY, input_valid low.
// - BUSY: capture lane_gc/ts01/ts10/ts11 on a rising edge of lane_output_valid[i] (low the previous cycle, high now).
//   The previous-value flop is cleared at issue, so a level left high from the prior job is never captured.
//   On capture -> DONE.
// - Operands (lane_ga/gb/r/gid) are held unchanged from load until DONE->IDLE.
//   The lane computes Gc1 from R combinationally, so R must not change before capture.
// - res_valid = (lane[ret_ptr]==DONE); res_* are mux of lane[ret_ptr] captured regs and gid.
//   res_* stable while res_valid && !res_ready.
// - On res_valid&&res_ready: lane -> IDLE; ret_ptr+1 mod N. Freed lane is acceptable from the next cycle.
// - Out-of-order lane completion is buffered in DONE; retirement order always equals acceptance order.
// - Accept and retire in the same cycle are legal; they can never target the same lane.
// - All lanes busy: job_ready=0 until the lane at disp_ptr retires; no job is dropped.
// - inflight updates one cycle after accept/retire; accept+retire in the same cycle leaves it unchanged.
// - Timeout: per-lane counter runs in ISSUE/BUSY, cleared on entry to ISSUE.
//   When it reaches TIMEOUT: timeout_err=1 (sticky until reset); lane keeps waiting, no recovery except reset.
// - Reset mid-operation: pending, issued and DONE results are discarded; lane_input_valid drops immediately (async).
// TESTING
// 1 Single job: Ga=80'h1, Gb=80'h2, R=80'h3, gid=5. Lane0 output_valid rises 20 cycles after issue.
//   -> exactly one lane_input_valid[0] pulse; res_valid the cycle after capture; res_gid=5; res_gc=lane_gc[0].
// 2 Fill: 5 jobs back-to-back, res_ready=0 -> lanes 0..3 issued, job_ready=0 for job 5, inflight=4.
//   Retire one -> job 5 goes to lane0 next cycle.
// 3 Out of order: lane1 completes 10 cycles before lane0 -> gid of lane0 job is retired first, then lane1.
//   res_* stable under res_ready=0 for 8 cycles.
// 4 Stale level: lane_output_valid[2] held high across retire and reissue -> no capture until it falls and rises again.
// 5 Timeout: TIMEOUT=16, lane0 output_valid never rises -> timeout_err=1 at issue+16; stays 1; other lanes continue.
// 6 Reset mid-op: assert reset_n=0 with 3 lanes busy -> all outputs 0 immediately.
//   After release the next job uses lane0 and res_gid matches it.

Source files
------------

// File: rtl/gate_dispatcher.sv
// gate_dispatcher
// Schedules garbled-AND gate jobs onto NUM_LANES evaluator_and lanes and
// retires their Gc/toSend tables in the same order the jobs were accepted.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   job_valid / job_ready        job stream handshake
//   job_ga, job_gb, job_r        input labels and global offset R (KW bits)
//   job_gid                      gate id (GW bits)
//   lane_input_valid[N]          one-cycle issue pulse per lane
//   lane_ga/gb/r[N*KW]           operands held per lane, lane i at [i*KW +: KW]
//   lane_gid[N*GW]               gate id held per lane
//   lane_ready[N]                lane can accept an issue
//   lane_output_valid[N]         lane digests valid (level)
//   lane_gc/ts01/ts10/ts11[N*KW] lane Gc and garbled table rows
//   res_valid / res_ready        result stream handshake
//   res_gid, res_gc, res_ts*     result of the oldest outstanding job
//   inflight                     number of lanes not IDLE
//   timeout_err                  sticky lane timeout flag
module gate_dispatcher #(
  parameter int NUM_LANES = 4,
  parameter int KW        = 80,
  parameter int GW        = 64,
  parameter int TIMEOUT   = 4095
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [KW-1:0]                   job_ga,
  input  logic [KW-1:0]                   job_gb,
  input  logic [KW-1:0]                   job_r,
  input  logic [GW-1:0]                   job_gid,
  output logic [NUM_LANES-1:0]            lane_input_valid,
  output logic [NUM_LANES*KW-1:0]         lane_ga,
  output logic [NUM_LANES*KW-1:0]         lane_gb,
  output logic [NUM_LANES*KW-1:0]         lane_r,
  output logic [NUM_LANES*GW-1:0]         lane_gid,
  input  logic [NUM_LANES-1:0]            lane_ready,
  input  logic [NUM_LANES-1:0]            lane_output_valid,
  input  logic [NUM_LANES*KW-1:0]         lane_gc,
  input  logic [NUM_LANES*KW-1:0]         lane_ts01,
  input  logic [NUM_LANES*KW-1:0]         lane_ts10,
  input  logic [NUM_LANES*KW-1:0]         lane_ts11,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [GW-1:0]                   res_gid,
  output logic [KW-1:0]                   res_gc,
  output logic [KW-1:0]                   res_ts01,
  output logic [KW-1:0]                   res_ts10,
  output logic [KW-1:0]                   res_ts11,
  output logic [$clog2(NUM_LANES):0]      inflight,
  output logic                            timeout_err
);

  localparam int PW = $clog2(NUM_LANES);
  localparam int IW = PW + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } lane_state_e;

  lane_state_e             state_q [NUM_LANES];
  lane_state_e             state_d [NUM_LANES];
  logic [NUM_LANES*KW-1:0] ga_q, ga_d, gb_q, gb_d, r_q, r_d;
  logic [NUM_LANES*GW-1:0] gid_q, gid_d;
  logic [NUM_LANES*KW-1:0] gc_q, gc_d, ts01_q, ts01_d, ts10_q, ts10_d, ts11_q, ts11_d;
  logic [NUM_LANES-1:0]    low_seen_q, low_seen_d;
  logic [TW-1:0]           cnt_q [NUM_LANES];
  logic [TW-1:0]           cnt_d [NUM_LANES];
  logic [PW-1:0]           disp_ptr_q, disp_ptr_d, ret_ptr_q, ret_ptr_d;
  logic [IW-1:0]           inflight_q, inflight_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    accept, retire;

  // Dispatch and retire pointers each look at exactly one lane, so both
  // handshakes depend only on registered lane state.
  assign job_ready   = (state_q[disp_ptr_q] == ST_IDLE);
  assign res_valid   = (state_q[ret_ptr_q] == ST_DONE);
  assign accept      = job_valid && job_ready;
  assign retire      = res_valid && res_ready;

  assign lane_ga     = ga_q;
  assign lane_gb     = gb_q;
  assign lane_r      = r_q;
  assign lane_gid    = gid_q;
  assign inflight    = inflight_q;
  assign timeout_err = timeout_err_q;

  // Issue pulse follows lane_ready while in ISSUE; it is derived from state
  // so an asynchronous reset removes it immediately.
  always_comb begin
    lane_input_valid = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_input_valid[i] = (state_q[i] == ST_ISSUE) && lane_ready[i];
    end
  end

  // Result mux from the lane at the retire pointer; captured registers only
  // change on capture, so outputs stay stable while waiting for res_ready.
  always_comb begin
    res_gid  = gid_q[int'(ret_ptr_q)*GW +: GW];
    res_gc   = gc_q[int'(ret_ptr_q)*KW +: KW];
    res_ts01 = ts01_q[int'(ret_ptr_q)*KW +: KW];
    res_ts10 = ts10_q[int'(ret_ptr_q)*KW +: KW];
    res_ts11 = ts11_q[int'(ret_ptr_q)*KW +: KW];
  end

  // Next-state logic for all lanes, pointers, occupancy and timeout.
  // low_seen acts as the edge detector's previous-value flop: it is cleared
  // when the job is loaded and set once the output_valid level is seen low
  // after that, so a level still high from the previous job cannot capture.
  always_comb begin
    ga_d          = ga_q;
    gb_d          = gb_q;
    r_d           = r_q;
    gid_d         = gid_q;
    gc_d          = gc_q;
    ts01_d        = ts01_q;
    ts10_d        = ts10_q;
    ts11_d        = ts11_q;
    low_seen_d    = low_seen_q;
    disp_ptr_d    = disp_ptr_q;
    ret_ptr_d     = ret_ptr_q;
    inflight_d    = inflight_q;
    timeout_err_d = timeout_err_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end

    if (accept) disp_ptr_d = disp_ptr_q + PW'(1);
    if (retire) ret_ptr_d  = ret_ptr_q + PW'(1);

    case ({accept, retire})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    for (int i = 0; i < NUM_LANES; i++) begin
      unique case (state_q[i])
        ST_IDLE: begin
          if (accept && (disp_ptr_q == PW'(i))) begin
            state_d[i]         = ST_ISSUE;
            ga_d[i*KW +: KW]   = job_ga;
            gb_d[i*KW +: KW]   = job_gb;
            r_d[i*KW +: KW]    = job_r;
            gid_d[i*GW +: GW]  = job_gid;
            low_seen_d[i]      = 1'b0;
            cnt_d[i]           = '0;
          end
        end
        ST_ISSUE: begin
          if (lane_ready[i]) state_d[i] = ST_BUSY;
        end
        ST_BUSY: begin
          if (lane_output_valid[i] && low_seen_q[i]) begin
            state_d[i]         = ST_DONE;
            gc_d[i*KW +: KW]   = lane_gc[i*KW +: KW];
            ts01_d[i*KW +: KW] = lane_ts01[i*KW +: KW];
            ts10_d[i*KW +: KW] = lane_ts10[i*KW +: KW];
            ts11_d[i*KW +: KW] = lane_ts11[i*KW +: KW];
          end
        end
        ST_DONE: begin
          if (retire && (ret_ptr_q == PW'(i))) state_d[i] = ST_IDLE;
        end
      endcase

      if ((state_q[i] == ST_ISSUE || state_q[i] == ST_BUSY) && !lane_output_valid[i]) begin
        low_seen_d[i] = 1'b1;
      end

      // Counts completed cycles in ISSUE/BUSY and saturates at TIMEOUT; the
      // flag rises as the count reaches TIMEOUT and never clears.
      if ((TIMEOUT > 0) && (state_q[i] == ST_ISSUE || state_q[i] == ST_BUSY) &&
          (cnt_q[i] != TMAX)) begin
        cnt_d[i] = cnt_q[i] + TW'(1);
        if (cnt_d[i] == TMAX) timeout_err_d = 1'b1;
      end
    end
  end

  // State registers; everything clears on reset, discarding in-flight jobs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      ga_q          <= '0;
      gb_q          <= '0;
      r_q           <= '0;
      gid_q         <= '0;
      gc_q          <= '0;
      ts01_q        <= '0;
      ts10_q        <= '0;
      ts11_q        <= '0;
      low_seen_q    <= '0;
      disp_ptr_q    <= '0;
      ret_ptr_q     <= '0;
      inflight_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ga_q          <= ga_d;
      gb_q          <= gb_d;
      r_q           <= r_d;
      gid_q         <= gid_d;
      gc_q          <= gc_d;
      ts01_q        <= ts01_d;
      ts10_q        <= ts10_d;
      ts11_q        <= ts11_d;
      low_seen_q    <= low_seen_d;
      disp_ptr_q    <= disp_ptr_d;
      ret_ptr_q     <= ret_ptr_d;
      inflight_q    <= inflight_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_gate_dispatcher.sv
// tb_gate_dispatcher
// Directed bench for gate_dispatcher (4 lanes, TIMEOUT=16). Inputs change on
// the falling edge and outputs are sampled there too. Lane i presents
// Gc=C00+i, toSend01=A00+i, toSend10=B00+i, toSend11=D00+i.
module tb_gate_dispatcher;

  logic          clk;
  logic          reset_n;
  logic          job_valid;
  logic          job_ready;
  logic [79:0]   job_ga, job_gb, job_r;
  logic [63:0]   job_gid;
  logic [3:0]    lane_input_valid;
  logic [319:0]  lane_ga, lane_gb, lane_r;
  logic [255:0]  lane_gid;
  logic [3:0]    lane_ready;
  logic [3:0]    lane_output_valid;
  logic [319:0]  lane_gc, lane_ts01, lane_ts10, lane_ts11;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_gid;
  logic [79:0]   res_gc, res_ts01, res_ts10, res_ts11;
  logic [2:0]    inflight;
  logic          timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  gate_dispatcher #(.NUM_LANES(4), .KW(80), .GW(64), .TIMEOUT(16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_ga            (job_ga),
    .job_gb            (job_gb),
    .job_r             (job_r),
    .job_gid           (job_gid),
    .lane_input_valid  (lane_input_valid),
    .lane_ga           (lane_ga),
    .lane_gb           (lane_gb),
    .lane_r            (lane_r),
    .lane_gid          (lane_gid),
    .lane_ready        (lane_ready),
    .lane_output_valid (lane_output_valid),
    .lane_gc           (lane_gc),
    .lane_ts01         (lane_ts01),
    .lane_ts10         (lane_ts10),
    .lane_ts11         (lane_ts11),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_gid           (res_gid),
    .res_gc            (res_gc),
    .res_ts01          (res_ts01),
    .res_ts10          (res_ts10),
    .res_ts11          (res_ts11),
    .inflight          (inflight),
    .timeout_err       (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_job(input logic [63:0] gid);
    job_valid = 1'b1;
    job_gid   = gid;
    job_ga    = {16'h0, gid};
    job_gb    = {16'h1, gid};
    job_r     = {16'h2, gid};
  endtask

  task automatic do_reset();
    reset_n           = 1'b0;
    job_valid         = 1'b0;
    job_ga            = '0;
    job_gb            = '0;
    job_r             = '0;
    job_gid           = '0;
    lane_ready        = 4'hF;
    lane_output_valid = 4'h0;
    res_ready         = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lane_gc[i*80 +: 80]   = 80'hC00 + 80'(i);
      lane_ts01[i*80 +: 80] = 80'hA00 + 80'(i);
      lane_ts10[i*80 +: 80] = 80'hB00 + 80'(i);
      lane_ts11[i*80 +: 80] = 80'hD00 + 80'(i);
    end
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (job_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_job_ready: got %b want 1", job_ready); end
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_res_valid: got %b want 0", res_valid); end
    tests_run++;
    if (lane_input_valid !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_input_valid: got %h want 0", lane_input_valid); end
    tests_run++;
    if (inflight !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_inflight: got %0d want 0", inflight); end
    tests_run++;
    if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout_err); end
    tests_run++;
    if (res_gid !== 64'h0 || res_gc !== 80'h0) begin tests_failed++; $display("[TB] FAIL reset_res_data: got %h/%h want 0/0", res_gid, res_gc); end
    tests_run++;
    if (lane_ga !== '0 || lane_gid !== '0) begin tests_failed++; $display("[TB] FAIL reset_operands: got %h want 0", lane_gid); end
  endtask

  task automatic test_single();
    int pulses;
    do_reset();
    set_job(64'd5);
    job_ga = 80'h1;
    job_gb = 80'h2;
    job_r  = 80'h3;
    tick();
    job_valid = 1'b0;
    tests_run++;
    if (lane_input_valid !== 4'b0001) begin tests_failed++; $display("[TB] FAIL single_issue: got %b want 0001", lane_input_valid); end
    tests_run++;
    if (lane_ga[79:0] !== 80'h1 || lane_gb[79:0] !== 80'h2 || lane_r[79:0] !== 80'h3)
      begin tests_failed++; $display("[TB] FAIL single_operands: got %h %h %h want 1 2 3", lane_ga[79:0], lane_gb[79:0], lane_r[79:0]); end
    tests_run++;
    if (lane_gid[63:0] !== 64'd5 || inflight !== 3'd1)
      begin tests_failed++; $display("[TB] FAIL single_gid_inflight: got %0d/%0d want 5/1", lane_gid[63:0], inflight); end
    pulses = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (lane_input_valid[0] === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("[TB] FAIL single_pulse_count: got %0d want 1", pulses); end
    tests_run++;
    if (res_valid !== 1'b0 || lane_r[79:0] !== 80'h3)
      begin tests_failed++; $display("[TB] FAIL single_pre_capture: got %b/%h want 0/3", res_valid, lane_r[79:0]); end
    lane_output_valid = 4'b0001;
    tick();
    tests_run++;
    if (res_valid !== 1'b1 || res_gid !== 64'd5)
      begin tests_failed++; $display("[TB] FAIL single_result: got %b/%0d want 1/5", res_valid, res_gid); end
    tests_run++;
    if (res_gc !== 80'hC00 || res_ts01 !== 80'hA00 || res_ts10 !== 80'hB00 || res_ts11 !== 80'hD00)
      begin tests_failed++; $display("[TB] FAIL single_tables: got %h %h %h %h want C00 A00 B00 D00", res_gc, res_ts01, res_ts10, res_ts11); end
    res_ready = 1'b1;
    tick();
    res_ready         = 1'b0;
    lane_output_valid = 4'b0000;
    tests_run++;
    if (res_valid !== 1'b0 || inflight !== 3'd0)
      begin tests_failed++; $display("[TB] FAIL single_retire: got %b/%0d want 0/0", res_valid, inflight); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_job(64'd10 + 64'(k));
      tick();
    end
    set_job(64'd14);
    tests_run++;
    if (job_ready !== 1'b0 || inflight !== 3'd4)
      begin tests_failed++; $display("[TB] FAIL fill_full: got ready=%b inflight=%0d want 0/4", job_ready, inflight); end
    tests_run++;
    if (lane_gid[63:0] !== 64'd10 || lane_gid[127:64] !== 64'd11 || lane_gid[191:128] !== 64'd12 || lane_gid[255:192] !== 64'd13)
      begin tests_failed++; $display("[TB] FAIL fill_gids: got %h want 13,12,11,10", lane_gid); end
    lane_output_valid = 4'b0001;
    tick();
    tests_run++;
    if (res_valid !== 1'b1 || res_gid !== 64'd10 || job_ready !== 1'b0)
      begin tests_failed++; $display("[TB] FAIL fill_first_done: got %b/%0d/%b want 1/10/0", res_valid, res_gid, job_ready); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tests_run++;
    if (job_ready !== 1'b1 || inflight !== 3'd3 || res_valid !== 1'b0)
      begin tests_failed++; $display("[TB] FAIL fill_freed: got ready=%b inflight=%0d rv=%b want 1/3/0", job_ready, inflight, res_valid); end
    tick();
    job_valid         = 1'b0;
    lane_output_valid = 4'b0000;
    tests_run++;
    if (lane_gid[63:0] !== 64'd14 || lane_input_valid !== 4'b0001 || inflight !== 3'd4)
      begin tests_failed++; $display("[TB] FAIL fill_job5_lane0: got gid=%0d iv=%b inflight=%0d want 14/0001/4", lane_gid[63:0], lane_input_valid, inflight); end
  endtask

  task automatic test_out_of_order();
    int early;
    do_reset();
    set_job(64'd20);
    tick();
    set_job(64'd21);
    tick();
    job_valid = 1'b0;
    tick();
    lane_output_valid = 4'b0010;
    early = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (res_valid !== 1'b0) early++;
    end
    tests_run++;
    if (early !== 0) begin tests_failed++; $display("[TB] FAIL ooo_hold_lane1: got %0d early cycles want 0", early); end
    lane_output_valid = 4'b0011;
    tick();
    tests_run++;
    if (res_valid !== 1'b1 || res_gid !== 64'd20 || res_gc !== 80'hC00 || res_ts11 !== 80'hD00)
      begin tests_failed++; $display("[TB] FAIL ooo_first: got %b/%0d/%h/%h want 1/20/C00/D00", res_valid, res_gid, res_gc, res_ts11); end
    lane_gc[79:0] = 80'hDEAD_BEEF;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests_run++;
      if (res_valid !== 1'b1 || res_gid !== 64'd20 || res_gc !== 80'hC00)
        begin tests_failed++; $display("[TB] FAIL ooo_stable: cycle %0d got %b/%0d/%h want 1/20/C00", k, res_valid, res_gid, res_gc); end
    end
    res_ready = 1'b1;
    tick();
    tests_run++;
    if (res_valid !== 1'b1 || res_gid !== 64'd21 || res_gc !== 80'hC01 || res_ts10 !== 80'hB01)
      begin tests_failed++; $display("[TB] FAIL ooo_second: got %b/%0d/%h/%h want 1/21/C01/B01", res_valid, res_gid, res_gc, res_ts10); end
    tick();
    res_ready = 1'b0;
    tests_run++;
    if (res_valid !== 1'b0 || inflight !== 3'd0)
      begin tests_failed++; $display("[TB] FAIL ooo_drained: got %b/%0d want 0/0", res_valid, inflight); end
  endtask

  task automatic test_stale_level();
    int early;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_job(64'd30 + 64'(k));
      tick();
    end
    job_valid = 1'b0;
    tick();
    lane_output_valid = 4'b0111;
    tick();
    tests_run++;
    if (res_valid !== 1'b1 || res_gid !== 64'd30)
      begin tests_failed++; $display("[TB] FAIL stale_r30: got %b/%0d want 1/30", res_valid, res_gid); end
    res_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (res_valid !== 1'b1 || res_gid !== 64'd32 || res_gc !== 80'hC02)
      begin tests_failed++; $display("[TB] FAIL stale_r32: got %b/%0d/%h want 1/32/C02", res_valid, res_gid, res_gc); end
    tick();
    res_ready         = 1'b0;
    lane_output_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      set_job(64'd33 + 64'(k));
      tick();
    end
    job_valid = 1'b0;
    tests_run++;
    if (lane_input_valid !== 4'b0100 || lane_gid[191:128] !== 64'd36)
      begin tests_failed++; $display("[TB] FAIL stale_reissue: got %b/%0d want 0100/36", lane_input_valid, lane_gid[191:128]); end
    tick();
    lane_output_valid = 4'b1111;
    tick();
    res_ready = 1'b1;
    tick();
    tick();
    tick();
    res_ready = 1'b0;
    early = 0;
    for (int k = 0; k < 5; k++) begin
      if (res_valid !== 1'b0) early++;
      tick();
    end
    tests_run++;
    if (early !== 0) begin tests_failed++; $display("[TB] FAIL stale_no_capture: got %0d valid cycles want 0", early); end
    lane_output_valid = 4'b1011;
    tick();
    lane_output_valid = 4'b1111;
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stale_low_phase: got %b want 0", res_valid); end
    tick();
    tests_run++;
    if (res_valid !== 1'b1 || res_gid !== 64'd36)
      begin tests_failed++; $display("[TB] FAIL stale_new_edge: got %b/%0d want 1/36", res_valid, res_gid); end
  endtask

  task automatic test_timeout();
    do_reset();
    set_job(64'd40);
    tick();
    tests_run++;
    if (lane_input_valid !== 4'b0001) begin tests_failed++; $display("[TB] FAIL to_issue0: got %b want 0001", lane_input_valid); end
    set_job(64'd41);
    tick();
    job_valid = 1'b0;
    tests_run++;
    if (lane_input_valid !== 4'b0010) begin tests_failed++; $display("[TB] FAIL to_issue1: got %b want 0010", lane_input_valid); end
    tick();
    lane_output_valid = 4'b0010;
    tick();
    tests_run++;
    if (res_valid !== 1'b0 || inflight !== 3'd2)
      begin tests_failed++; $display("[TB] FAIL to_lane1_done: got %b/%0d want 0/2", res_valid, inflight); end
    repeat (12) tick();
    tests_run++;
    if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_early: got %b want 0 at issue+15", timeout_err); end
    tick();
    tests_run++;
    if (timeout_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_set: got %b want 1 at issue+16", timeout_err); end
    repeat (10) tick();
    tests_run++;
    if (timeout_err !== 1'b1 || job_ready !== 1'b1)
      begin tests_failed++; $display("[TB] FAIL to_sticky: got err=%b ready=%b want 1/1", timeout_err, job_ready); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_job(64'd50 + 64'(k));
      tick();
    end
    job_valid = 1'b0;
    tests_run++;
    if (lane_input_valid !== 4'b0100 || inflight !== 3'd3)
      begin tests_failed++; $display("[TB] FAIL midop_busy: got %b/%0d want 0100/3", lane_input_valid, inflight); end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (lane_input_valid !== 4'h0 || inflight !== 3'd0 || res_valid !== 1'b0)
      begin tests_failed++; $display("[TB] FAIL midop_async: got %b/%0d/%b want 0/0/0", lane_input_valid, inflight, res_valid); end
    tests_run++;
    if (lane_gid !== '0 || lane_ga !== '0 || res_gid !== 64'h0)
      begin tests_failed++; $display("[TB] FAIL midop_data_clear: got %h want 0", lane_gid); end
    tick();
    reset_n = 1'b1;
    set_job(64'd53);
    tick();
    job_valid = 1'b0;
    tests_run++;
    if (lane_input_valid !== 4'b0001 || lane_gid[63:0] !== 64'd53)
      begin tests_failed++; $display("[TB] FAIL midop_lane0: got %b/%0d want 0001/53", lane_input_valid, lane_gid[63:0]); end
    tick();
    lane_output_valid = 4'b0001;
    tick();
    tests_run++;
    if (res_valid !== 1'b1 || res_gid !== 64'd53)
      begin tests_failed++; $display("[TB] FAIL midop_result: got %b/%0d want 1/53", res_valid, res_gid); end
  endtask

  initial begin
    reset_n           = 1'b0;
    job_valid         = 1'b0;
    res_ready         = 1'b0;
    lane_ready        = 4'h0;
    lane_output_valid = 4'h0;
    test_reset();
    test_single();
    test_fill();
    test_out_of_order();
    test_stale_level();
    test_timeout();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
